// File: rtl/main_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// main_ctrl_pkg
// Shared definitions for the multicycle MIPS-subset main controller:
//   - OPCODE_WIDTH and the OP_* opcode constants (LW, SW, BEQ, R-type)
//   - ALUOP_* values, in the encoding alu_ctrl already expects
//   - CTRL_* state encodings (4-bit)
//   - ctrl_out_t, the bundle of datapath strobes and mux selects
// Configuration macro: MAIN_CTRL_ILLEGAL_TRAP_EN adds the CTRL_HALT encoding.
// ----------------------------------------------------------------------------
package main_ctrl_pkg;

    localparam int OPCODE_WIDTH = 6;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [1:0] ALUOP_LW    = 2'b00;
    localparam logic [1:0] ALUOP_SW    = 2'b01;
    localparam logic [1:0] ALUOP_BEQ   = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    typedef enum logic [3:0] {
        CTRL_FETCH  = 4'd0,
        CTRL_DECODE = 4'd1,
        CTRL_MEMADR = 4'd2,
        CTRL_MEMRD  = 4'd3,
        CTRL_MEMWB  = 4'd4,
        CTRL_MEMWR  = 4'd5,
        CTRL_EXEC   = 4'd6,
        CTRL_ALUWB  = 4'd7,
        CTRL_BRANCH = 4'd8
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        ,
        CTRL_HALT   = 4'd9
`endif
    } ctrl_state_e;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
    } ctrl_out_t;

endpackage

// File: rtl/main_ctrl_outdec.sv
// ----------------------------------------------------------------------------
// main_ctrl_outdec
// Purely combinational decode of the controller state into datapath strobes.
// Mostly Moore; ir_write/pc_en in FETCH follow mem_ready and pc_en in BRANCH
// follows the ALU zero flag (Mealy terms).
// Ports:
//   state     in  current controller state
//   opcode    in  instruction opcode (selects LW/SW alu_op in MEMADR)
//   mem_ready in  memory handshake
//   zero      in  ALU zero flag
//   ctrl      out decoded strobes / selects (all 0 for HALT and bad encodings)
// ----------------------------------------------------------------------------
module main_ctrl_outdec
    import main_ctrl_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_WIDTH
) (
    input  ctrl_state_e         state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output ctrl_out_t           ctrl
);

    // State to strobe decode; everything not named for a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            CTRL_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_op    = ALUOP_LW;
                // IR and PC advance only on the cycle the fetch completes.
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            CTRL_DECODE: begin
                // Precompute branch target into ALUOut.
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_op    = ALUOP_LW;
            end
            CTRL_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                if (opcode == OP_SW) begin
                    ctrl.alu_op = ALUOP_SW;
                end else begin
                    ctrl.alu_op = ALUOP_LW;
                end
            end
            CTRL_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            CTRL_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            CTRL_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            CTRL_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_RTYPE;
            end
            CTRL_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            CTRL_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_op    = ALUOP_BEQ;
                ctrl.pc_source = 1'b1;
                ctrl.pc_en     = zero;
            end
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
            CTRL_HALT: begin
                ctrl = '0;
            end
`endif
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/main_ctrl.sv
// ----------------------------------------------------------------------------
// main_ctrl
// Multicycle main control FSM for the MIPS-subset datapath (LW, SW, BEQ,
// R-type). Holds the state register and next-state logic; strobe decode is
// in main_ctrl_outdec. Stalls in FETCH/MEMRD/MEMWR until mem_ready.
// Configuration macro: MAIN_CTRL_ILLEGAL_TRAP_EN
//   defined   - unknown opcode in DECODE traps to HALT, illegal_op sticky
//   undefined - unknown opcode is a NOP, illegal_op tied 0
// Ports:
//   clk, rst (sync, active-high), ir_opcode, mem_ready, zero  - inputs
//   pc_en, ir_write, mem_read, mem_write, i_or_d, mem_to_reg, reg_dst,
//   reg_write, alu_src_a, alu_src_b[1:0], alu_op[1:0], pc_source,
//   illegal_op                                                - outputs
// All outputs are forced to 0 in any cycle where rst is high.
// ----------------------------------------------------------------------------
module main_ctrl
    import main_ctrl_pkg::*;
#(
    parameter int OPCODE_W = OPCODE_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                mem_ready,
    input  logic                zero,
    output logic                pc_en,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                pc_source,
    output logic                illegal_op
);

    ctrl_state_e state_q;
    ctrl_state_e state_d;
    ctrl_out_t   dec_s;
    ctrl_out_t   out_s;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CTRL_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CTRL_FETCH: begin
                if (mem_ready) begin
                    state_d = CTRL_DECODE;
                end else begin
                    state_d = CTRL_FETCH;
                end
            end
            CTRL_DECODE: begin
                case (ir_opcode)
                    OP_LW, OP_SW: state_d = CTRL_MEMADR;
                    OP_RTYPE:     state_d = CTRL_EXEC;
                    OP_BEQ:       state_d = CTRL_BRANCH;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = CTRL_HALT;
`else
                    default:      state_d = CTRL_FETCH;
`endif
                endcase
            end
            CTRL_MEMADR: begin
                // Only LW and SW reach here; the opcode picks the access type.
                if (ir_opcode == OP_SW) begin
                    state_d = CTRL_MEMWR;
                end else begin
                    state_d = CTRL_MEMRD;
                end
            end
            CTRL_MEMRD: begin
                if (mem_ready) begin
                    state_d = CTRL_MEMWB;
                end else begin
                    state_d = CTRL_MEMRD;
                end
            end
            CTRL_MEMWB: state_d = CTRL_FETCH;
            CTRL_MEMWR: begin
                if (mem_ready) begin
                    state_d = CTRL_FETCH;
                end else begin
                    state_d = CTRL_MEMWR;
                end
            end
            CTRL_EXEC:   state_d = CTRL_ALUWB;
            CTRL_ALUWB:  state_d = CTRL_FETCH;
            CTRL_BRANCH: state_d = CTRL_FETCH;
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
            CTRL_HALT:   state_d = CTRL_HALT;
`endif
            // Unreachable encodings recover to FETCH.
            default:     state_d = CTRL_FETCH;
        endcase
    end

    main_ctrl_outdec #(
        .OPCODE_W (OPCODE_W)
    ) u_outdec (
        .state     (state_q),
        .opcode    (ir_opcode),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (dec_s)
    );

    // Reset overrides every strobe, including Moore values, so an abandoned
    // instruction can never write memory, registers or the PC.
    always_comb begin
        if (rst) begin
            out_s = '0;
        end else begin
            out_s = dec_s;
        end
    end

    assign pc_en      = out_s.pc_en;
    assign ir_write   = out_s.ir_write;
    assign mem_read   = out_s.mem_read;
    assign mem_write  = out_s.mem_write;
    assign i_or_d     = out_s.i_or_d;
    assign mem_to_reg = out_s.mem_to_reg;
    assign reg_dst    = out_s.reg_dst;
    assign reg_write  = out_s.reg_write;
    assign alu_src_a  = out_s.alu_src_a;
    assign alu_src_b  = out_s.alu_src_b;
    assign alu_op     = out_s.alu_op;
    assign pc_source  = out_s.pc_source;

`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic illegal_d;

    // Sticky flag: set on entry to HALT, cleared only by reset.
    always_comb begin
        illegal_d = illegal_q | (state_d == CTRL_HALT);
    end

    // Illegal flag register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q & ~rst;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_main_ctrl.sv
// ----------------------------------------------------------------------------
// tb_main_ctrl
// Self-checking bench for main_ctrl. A step-per-instruction behavioural model
// predicts every output each cycle; directed sequences pin latencies and
// specific strobes with literal values; a random phase follows.
// ----------------------------------------------------------------------------
module tb_main_ctrl;

    localparam logic [5:0] B_LW  = 6'b100011;
    localparam logic [5:0] B_SW  = 6'b101011;
    localparam logic [5:0] B_BEQ = 6'b000100;
    localparam logic [5:0] B_R   = 6'b000000;

    typedef struct packed {
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
        logic       illegal_op;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] ir_opcode = 6'b000000;
    logic       mem_ready = 1'b1;
    logic       zero = 1'b0;
    logic       pc_en, ir_write, mem_read, mem_write, i_or_d, mem_to_reg;
    logic       reg_dst, reg_write, alu_src_a, pc_source, illegal_op;
    logic [1:0] alu_src_b, alu_op;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;

    // Model: position within the current instruction (0 = fetch, 1 = decode,
    // 2.. = instruction-specific steps) plus halted flag.
    int         m_step = 0;
    bit         m_halt = 1'b0;
    logic [5:0] m_op   = 6'b000000;

    vec_t seen [0:15];

    always #5 clk = ~clk;

    main_ctrl #(.OPCODE_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_opcode  (ir_opcode),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .pc_en      (pc_en),
        .ir_write   (ir_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .illegal_op (illegal_op)
    );

    function automatic vec_t dut_vec();
        vec_t v;
        v.pc_en = pc_en;         v.ir_write = ir_write;   v.mem_read = mem_read;
        v.mem_write = mem_write; v.i_or_d = i_or_d;       v.mem_to_reg = mem_to_reg;
        v.reg_dst = reg_dst;     v.reg_write = reg_write; v.alu_src_a = alu_src_a;
        v.alu_src_b = alu_src_b; v.alu_op = alu_op;       v.pc_source = pc_source;
        v.illegal_op = illegal_op;
        return v;
    endfunction

    // 0 = LW, 1 = SW, 2 = R-type, 3 = BEQ, 4 = unknown
    function automatic int op_class(input logic [5:0] op);
        if (op == B_LW)  return 0;
        if (op == B_SW)  return 1;
        if (op == B_R)   return 2;
        if (op == B_BEQ) return 3;
        return 4;
    endfunction

    function automatic vec_t model_out(input int step, input bit halt, input logic [5:0] op,
                                       input logic mr, input logic z, input logic r);
        vec_t v = '0;
        if (r) return v;
        if (halt) begin
            v.illegal_op = 1'b1;
            return v;
        end
        if (step == 0) begin
            v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ir_write = mr; v.pc_en = mr;
        end else if (step == 1) begin
            v.alu_src_b = 2'b11;
        end else begin
            case (op_class(op))
                0: begin
                    if (step == 2) begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 2'b00; end
                    if (step == 3) begin v.mem_read = 1'b1; v.i_or_d = 1'b1; end
                    if (step == 4) begin v.reg_write = 1'b1; v.mem_to_reg = 1'b1; end
                end
                1: begin
                    if (step == 2) begin v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 2'b01; end
                    if (step == 3) begin v.mem_write = 1'b1; v.i_or_d = 1'b1; end
                end
                2: begin
                    if (step == 2) begin v.alu_src_a = 1'b1; v.alu_op = 2'b11; end
                    if (step == 3) begin v.reg_write = 1'b1; v.reg_dst = 1'b1; end
                end
                3: begin
                    v.alu_src_a = 1'b1; v.alu_op = 2'b10; v.pc_source = 1'b1; v.pc_en = z;
                end
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    // Next step; -1 means trap to halt.
    function automatic int model_next(input int step, input logic [5:0] op, input logic mr);
        int cls = op_class(op);
        if (step == 0) return mr ? 1 : 0;
        if (step == 1) begin
            if (cls == 4) begin
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
                return -1;
`else
                return 0;
`endif
            end
            return 2;
        end
        if (step == 2) return (cls == 3) ? 0 : 3;
        if (step == 3) begin
            if (cls == 0) return mr ? 4 : 3;
            if (cls == 1) return mr ? 0 : 3;
            return 0;
        end
        return 0;
    endfunction

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        if (chk_on) begin
            vec_t exp_v;
            vec_t act_v;
            int   nxt;
            exp_v = model_out(m_step, m_halt, (m_step == 1) ? ir_opcode : m_op, mem_ready, zero, rst);
            act_v = dut_vec();
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL cycle_cmp step=%0d: got %b, expected %b (t=%0t)", m_step, act_v, exp_v, $time);
            end
            if (rst) begin
                m_step = 0;
                m_halt = 1'b0;
            end else if (!m_halt) begin
                if (m_step == 1) m_op = ir_opcode;
                nxt = model_next(m_step, m_op, mem_ready);
                if (m_step == 1) nxt = model_next(1, ir_opcode, mem_ready);
                if (nxt < 0) m_halt = 1'b1;
                else m_step = nxt;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one instruction from a FETCH cycle (called at posedge+1); waits
    // are mem_ready-low cycles inserted in MEMRD/MEMWR.
    task automatic do_instr(input logic [5:0] op, input int waits, input logic z, output int ncyc);
        int wcnt = 0;
        ir_opcode = op;
        zero      = z;
        mem_ready = 1'b1;
        ncyc      = 0;
        for (int c = 0; c < 16; c++) begin
            #2;
            seen[c] = dut_vec();
            tick();
            ncyc++;
            if (m_step == 0 || m_halt) break;
            if (m_step == 3 && (op == B_LW || op == B_SW) && wcnt < waits) begin
                mem_ready = 1'b0;
                wcnt++;
            end else begin
                mem_ready = 1'b1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt_w;
        int cnt_rw;
        bit hit;

        // Reset held for two cycles with mem_ready high.
        tick();
        chk_on = 1'b1;
        #2 lit("reset_c1_all_zero", dut_vec(), 32'd0);
        tick();
        #2 lit("reset_c2_all_zero", dut_vec(), 32'd0);
        tick();
        rst = 1'b0;

        // LW, no waits.
        do_instr(B_LW, 0, 1'b0, n);
        lit("fetch_mem_read", seen[0].mem_read, 32'd1);
        lit("fetch_ir_write", seen[0].ir_write, 32'd1);
        lit("fetch_pc_en", seen[0].pc_en, 32'd1);
        lit("fetch_alu_src_b", seen[0].alu_src_b, 32'd1);
        lit("lw_cycles", n, 32'd5);
        lit("lw_memadr_alu_op", seen[2].alu_op, 32'd0);
        lit("lw_wb_reg_write", seen[4].reg_write, 32'd1);
        lit("lw_wb_mem_to_reg", seen[4].mem_to_reg, 32'd1);

        // SW with three wait cycles in MEMWR.
        do_instr(B_SW, 3, 1'b0, n);
        lit("sw_cycles", n, 32'd7);
        cnt_w  = 0;
        cnt_rw = 0;
        for (int k = 0; k < n && k < 16; k++) begin
            if (seen[k].mem_write && seen[k].i_or_d) cnt_w++;
            if (seen[k].reg_write) cnt_rw++;
        end
        lit("sw_mem_write_cycles", cnt_w, 32'd4);
        lit("sw_no_reg_write", cnt_rw, 32'd0);
        lit("sw_memadr_alu_op", seen[2].alu_op, 32'd1);

        // R-type.
        do_instr(B_R, 0, 1'b0, n);
        lit("rtype_cycles", n, 32'd4);
        lit("rtype_exec_alu_op", seen[2].alu_op, 32'd3);
        lit("rtype_wb_reg_write", seen[3].reg_write, 32'd1);
        lit("rtype_wb_reg_dst", seen[3].reg_dst, 32'd1);

        // BEQ taken and not taken.
        do_instr(B_BEQ, 0, 1'b1, n);
        lit("beq_cycles", n, 32'd3);
        lit("beq_taken_pc_en", seen[2].pc_en, 32'd1);
        lit("beq_pc_source", seen[2].pc_source, 32'd1);
        lit("beq_alu_op", seen[2].alu_op, 32'd2);
        do_instr(B_BEQ, 0, 1'b0, n);
        lit("beq_not_taken_pc_en", seen[2].pc_en, 32'd0);

        // Unknown opcode.
        do_instr(6'b111111, 0, 1'b0, n);
        lit("illegal_decode_cycles", n, 32'd2);
`ifdef MAIN_CTRL_ILLEGAL_TRAP_EN
        ir_opcode = B_LW;
        tick();
        tick();
        tick();
        #2 lit("halt_illegal_op_set", illegal_op, 32'd1);
        lit("halt_no_mem_read", mem_read, 32'd0);
        tick();
        rst = 1'b1;
        #2 lit("halt_rst_gates_flag", illegal_op, 32'd0);
        tick();
        rst = 1'b0;
        #2 lit("halt_flag_cleared", illegal_op, 32'd0);
        lit("halt_rst_to_fetch", mem_read, 32'd1);
`else
        lit("nop_illegal_op_zero", seen[1].illegal_op, 32'd0);
        #2 lit("nop_back_to_fetch", mem_read, 32'd1);
`endif

        // Reset asserted during MEMRD.
        tick();
        ir_opcode = B_LW;
        mem_ready = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_step == 3 && !m_halt) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        lit("reached_memrd", hit, 32'd1);
        lit("memrd_i_or_d", i_or_d, 32'd1);
        rst = 1'b1;
        #2 lit("rst_mid_no_reg_write", reg_write, 32'd0);
        lit("rst_mid_all_zero", dut_vec(), 32'd0);
        tick();
        rst = 1'b0;
        #2 lit("rst_mid_next_fetch_mem_read", mem_read, 32'd1);
        lit("rst_mid_next_fetch_src_b", alu_src_b, 32'd1);
        lit("rst_mid_next_fetch_i_or_d", i_or_d, 32'd0);

        // Random phase, checked every cycle by the model.
        for (int c = 0; c < 3000; c++) begin
            int r;
            tick();
            rst       = ($urandom_range(0, 149) == 0);
            mem_ready = ($urandom_range(0, 3) != 0);
            zero      = $urandom_range(0, 1);
            if (m_step == 0 || m_halt) begin
                r = $urandom_range(0, 15);
                if (r < 4)       ir_opcode = B_LW;
                else if (r < 8)  ir_opcode = B_SW;
                else if (r < 11) ir_opcode = B_R;
                else if (r < 14) ir_opcode = B_BEQ;
                else             ir_opcode = 6'($urandom_range(0, 63));
            end
        end
        tick();
        chk_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
